// File: rtl/icache_pkg.sv
// Shared types and default geometry for the 2-way instruction cache.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, UPDATE} state_t;

  localparam int DEF_NUM_SETS   = 8;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_WAYS       = 2;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  localparam int OFFSET_W = offset_w(DEF_LINE_WORDS);
  localparam int INDEX_W  = $clog2(DEF_NUM_SETS);
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data storage, combinational lookup and a full-line
// write port used when a refilled line is installed.
module icache_way
  import icache_pkg::*;
#(
  parameter int  NUM_SETS   = DEF_NUM_SETS,
  parameter int  LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W      = $clog2(NUM_SETS),
  localparam int WRD_W      = $clog2(LINE_WORDS),
  localparam int TG_W       = 32 - IDX_W - WRD_W - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush_all,
  input  logic [IDX_W-1:0]        i_rd_index,
  input  logic [WRD_W-1:0]        i_rd_word,
  input  logic [TG_W-1:0]         i_rd_tag,
  output logic                    o_valid,
  output logic                    o_match,
  output logic [31:0]             o_rdata,
  input  logic                    i_wr_en,
  input  logic                    i_wr_valid,
  input  logic [IDX_W-1:0]        i_wr_index,
  input  logic [TG_W-1:0]         i_wr_tag,
  input  logic [LINE_WORDS*32-1:0] i_wr_line
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TG_W-1:0]     r_tag [NUM_SETS];
  logic [31:0]         w_word [LINE_WORDS];

  // A write in the same cycle as a flush wins for its own set only when the
  // caller says the installed line is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_flush_all)
        r_valid <= '0;
      if (i_wr_en && i_wr_valid)
        r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_tag[i_wr_index] <= i_wr_tag;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] r_mem [NUM_SETS];
      always_ff @(posedge clk) begin
        if (i_wr_en)
          r_mem[i_wr_index] <= i_wr_line[gi*32 +: 32];
      end
      assign w_word[gi] = r_mem[i_rd_index];
    end
  endgenerate

  assign o_valid = r_valid[i_rd_index];
  assign o_match = o_valid && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rdata = w_word[i_rd_word];

endmodule

// File: rtl/icache_fetch.sv
// 2-way set-associative instruction cache with word-by-word line refill.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int WAYS       = DEF_WAYS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = offset_w(LINE_WORDS);
  localparam int TG_W  = 32 - OFF_W - IDX_W;
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [WRD_W-1:0]         r_beat;
  logic [TG_W+IDX_W-1:0]    r_line_addr;
  logic                     r_victim;
  logic                     r_flush_pend;
  logic [NUM_SETS-1:0]      r_lru;
  logic [31:0]              r_line_buf [LINE_WORDS];

  logic [IDX_W-1:0]         w_idx;
  logic [WRD_W-1:0]         w_word;
  logic [TG_W-1:0]          w_tag;
  logic                     w_lookup;
  logic                     w_hit;
  logic                     w_hit_way;
  logic                     w_victim;
  logic                     w_flush_all;
  logic                     w_install_valid;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [LINE_WORDS*32-1:0] w_line;
  logic [WAYS-1:0]          w_valid;
  logic [WAYS-1:0]          w_match;
  logic [WAYS-1:0]          w_wr_en;
  logic [31:0]              w_rdata [WAYS];
  logic                     w_unused;

  assign w_idx    = addr[OFF_W +: IDX_W];
  assign w_word   = addr[2 +: WRD_W];
  assign w_tag    = addr[OFF_W+IDX_W +: TG_W];
  assign w_unused = ^addr[1:0];

  // Lookups are suppressed while reset is held so stall drops immediately.
  assign w_lookup  = (r_state == IDLE) && req && !rst;
  assign w_hit     = w_lookup && (|w_match);
  assign w_hit_way = !w_match[0];
  assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);

  assign w_install_valid = !(r_flush_pend || flush);
  assign w_flush_all = ((r_state == IDLE) && flush) ||
                       ((r_state == UPDATE) && !w_install_valid);
  assign w_wr_idx = r_line_addr[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
      assign w_line[gi*32 +: 32] = r_line_buf[gi];
    end

    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_wr_en[gi] = (r_state == UPDATE) && (r_victim == 1'(gi));
      icache_way #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS)
      ) u_way (
        .clk         (clk),
        .rst         (rst),
        .i_flush_all (w_flush_all),
        .i_rd_index  (w_idx),
        .i_rd_word   (w_word),
        .i_rd_tag    (w_tag),
        .o_valid     (w_valid[gi]),
        .o_match     (w_match[gi]),
        .o_rdata     (w_rdata[gi]),
        .i_wr_en     (w_wr_en[gi]),
        .i_wr_valid  (w_install_valid),
        .i_wr_index  (w_wr_idx),
        .i_wr_tag    (r_line_addr[IDX_W +: TG_W]),
        .i_wr_line   (w_line)
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    hit          = 1'b0;
    instr_valid  = 1'b0;
    instr        = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    case (r_state)
      IDLE: begin
        if (w_lookup) begin
          if (w_hit) begin
            hit         = 1'b1;
            instr_valid = 1'b1;
            instr       = w_match[0] ? w_rdata[0] : w_rdata[1];
          end else begin
            stall        = 1'b1;
            w_state_next = REFILL;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {r_line_addr, r_beat, 2'b00};
        if (mem_rvalid && (r_beat == LAST_BEAT))
          w_state_next = UPDATE;
      end
      UPDATE: begin
        stall        = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // LRU bit per set names the way to evict next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat       <= '0;
      r_line_addr  <= '0;
      r_victim     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_lru        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_lookup) begin
            if (w_hit) begin
              r_lru[w_idx] <= ~w_hit_way;
            end else begin
              r_line_addr <= addr[31:OFF_W];
              r_victim    <= w_victim;
              r_beat      <= '0;
            end
          end
        end
        REFILL: begin
          if (flush)
            r_flush_pend <= 1'b1;
          if (mem_rvalid)
            r_beat <= r_beat + 1'b1;
        end
        UPDATE: begin
          r_lru[w_wr_idx] <= ~r_victim;
          r_flush_pend    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == REFILL) && mem_rvalid)
      r_line_buf[r_beat] <= mem_rdata;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_lookup) begin
      if (w_hit)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      else
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule
